buffer_id_ex: RTL and testbench
===============================

Name: buffer_id_ex

Overview:
- ID/EX pipeline register for the MIPS datapath.
- Sits directly downstream of the register bank. It captures the bank's two read ports (data1/data2), the decoded instruction fields and the control word, and presents them to the EX stage one cycle later.
- Contains load-use hazard detection. On a hazard it requests a stall upstream and inserts a bubble.
- Supports flush on a taken branch and keeps a saturating bubble counter for debug.

Parameters:
- DATA_W, 32, width of register data and of the sign-extended immediate.
- CNT_W, 16, width of the bubble statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instrId  in  32  instruction in ID.
- validId  in  1  instrId/data are a real instruction.
- data1  in  DATA_W  register bank read port 1 (rs).
- data2  in  DATA_W  register bank read port 2 (rt).
- regWriteId, memReadId, memWriteId, memToRegId, aluSrcId, regDstId  in  1 each  control bits from decoder.
- aluOpId  in  3  ALU operation code.
- flush  in  1  taken branch; squash the instruction entering EX.
- stall  out  1  freeze PC and IF/ID (combinational).
- validEx  out  1  EX entry holds a real instruction.
- data1Ex, data2Ex  out  DATA_W  latched operands.
- immEx  out  DATA_W  sign-extended instrId[15:0].
- rsEx, rtEx, wAddrEx  out  5 each  latched rs, rt, and destination register.
- regWriteEx, memReadEx, memWriteEx, memToRegEx, aluSrcEx  out  1 each  latched control bits.
- aluOpEx  out  3  latched ALU op.
- bubbleCount  out  CNT_W  number of bubbles inserted, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output goes to 0 immediately and stays 0 while rst_n is low. This covers validEx, all data/addr/control outputs and bubbleCount. stall is 0 during reset because validEx=0.
- Field decode on the ID side: rs=instrId[25:21], rt=instrId[20:16], rd=instrId[15:11].
  - immEx = {16{instrId[15]}, instrId[15:0]}.
  - wAddrEx captured as regDstId ? rd : rt.
- Hazard (combinational): hazard = validEx & memReadEx & (rtEx!=0) & validId & (rtEx==rs | rtEx==rt).
  - stall = hazard & ~flush.
- Each rising clk, first matching rule wins:
  1. flush=1: validEx<=0 and all control outputs <=0. Data and address outputs are don't-care; implementation clears them to 0. bubbleCount is unchanged. A flush is not a bubble.
  2. hazard=1: insert bubble. validEx<=0 and all control bits <=0. data/addr outputs hold their previous values. bubbleCount<=bubbleCount+1 unless it already equals all-ones (saturate).
  3. Otherwise: capture.
     - validEx<=validId.
     - Control outputs take the ID values gated by validId; if validId=0 all control outputs are 0.
     - data1Ex<=data1, data2Ex<=data2, fields as above.
- Latency: exactly 1 cycle from ID inputs to EX outputs.
- Bubble behaviour: lasts exactly one cycle. Next cycle validEx=0, so hazard clears and the stalled instruction, still held upstream, is captured.
- Register $0: never causes a hazard (rtEx==0 excluded). Writes to $0 are the register bank's concern, not filtered here.
- Simultaneous flush and hazard: flush wins, stall=0, no count.
- Reset asserted mid-stall: outputs clear asynchronously. After release the first edge behaves as a normal capture.
- Registered outputs have no combinational path from inputs; only stall is combinational.

Test Plan:
1. Reset: hold rst_n=0 with random inputs, then release -> all outputs 0, bubbleCount=0. Re-assert rst_n asynchronously between edges -> outputs 0 immediately.
2. Normal capture: instrId=0x8C430010 (lw $3,16($2)), data1=0x100, data2=0x55, memReadId=regWriteId=aluSrcId=1, regDstId=0, validId=1 -> next edge: rsEx=2, rtEx=3, wAddrEx=3, immEx=0x10, data1Ex=0x100, memReadEx=1, validEx=1.
3. Load-use: EX holds lw $3; ID presents add $5,$3,$4 (0x00642820) -> stall=1. Next edge validEx=0, controls 0, bubbleCount=1. Following edge captures the add with rsEx=3, wAddrEx=5.
4. No hazard on $0: EX holds lw $0,0($1); ID uses rs=0 -> stall=0, add captured directly.
5. Flush priority: load-use condition present and flush=1 -> stall=0. Next edge validEx=0, bubbleCount unchanged.
6. Saturation with CNT_W=2: force 5 consecutive load-use bubbles -> bubbleCount sequence 1,2,3,3,3.

Source files
------------

// File: rtl/buffer_id_ex.sv
// rtl/buffer_id_ex.sv - ID/EX pipeline register with load-use hazard detection, flush and bubble counter
module buffer_id_ex #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instrId,
    input  logic              validId,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              regWriteId,
    input  logic              memReadId,
    input  logic              memWriteId,
    input  logic              memToRegId,
    input  logic              aluSrcId,
    input  logic              regDstId,
    input  logic [2:0]        aluOpId,
    input  logic              flush,
    output logic              stall,
    output logic              validEx,
    output logic [DATA_W-1:0] data1Ex,
    output logic [DATA_W-1:0] data2Ex,
    output logic [DATA_W-1:0] immEx,
    output logic [4:0]        rsEx,
    output logic [4:0]        rtEx,
    output logic [4:0]        wAddrEx,
    output logic              regWriteEx,
    output logic              memReadEx,
    output logic              memWriteEx,
    output logic              memToRegEx,
    output logic              aluSrcEx,
    output logic [2:0]        aluOpEx,
    output logic [CNT_W-1:0]  bubbleCount
);

    logic [4:0] rs, rt, rd;
    logic       hazard;
    wire        unused_opcode = ^instrId[31:26];

    assign rs = instrId[25:21];
    assign rt = instrId[20:16];
    assign rd = instrId[15:11];

    // A load in EX whose destination is read in ID cannot forward in time; $0 never matches.
    assign hazard = validEx & memReadEx & (rtEx != 5'd0) & validId &
                    ((rtEx == rs) | (rtEx == rt));
    assign stall  = hazard & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validEx     <= 1'b0;
            data1Ex     <= '0;
            data2Ex     <= '0;
            immEx       <= '0;
            rsEx        <= '0;
            rtEx        <= '0;
            wAddrEx     <= '0;
            regWriteEx  <= 1'b0;
            memReadEx   <= 1'b0;
            memWriteEx  <= 1'b0;
            memToRegEx  <= 1'b0;
            aluSrcEx    <= 1'b0;
            aluOpEx     <= '0;
            bubbleCount <= '0;
        end else if (flush) begin
            validEx     <= 1'b0;
            data1Ex     <= '0;
            data2Ex     <= '0;
            immEx       <= '0;
            rsEx        <= '0;
            rtEx        <= '0;
            wAddrEx     <= '0;
            regWriteEx  <= 1'b0;
            memReadEx   <= 1'b0;
            memWriteEx  <= 1'b0;
            memToRegEx  <= 1'b0;
            aluSrcEx    <= 1'b0;
            aluOpEx     <= '0;
        end else if (hazard) begin
            // Bubble: operands and addresses keep their old values, only control is killed.
            validEx    <= 1'b0;
            regWriteEx <= 1'b0;
            memReadEx  <= 1'b0;
            memWriteEx <= 1'b0;
            memToRegEx <= 1'b0;
            aluSrcEx   <= 1'b0;
            aluOpEx    <= '0;
            if (bubbleCount != '1)
                bubbleCount <= bubbleCount + CNT_W'(1);
        end else begin
            validEx    <= validId;
            data1Ex    <= data1;
            data2Ex    <= data2;
            immEx      <= {{(DATA_W-16){instrId[15]}}, instrId[15:0]};
            rsEx       <= rs;
            rtEx       <= rt;
            wAddrEx    <= regDstId ? rd : rt;
            regWriteEx <= regWriteId & validId;
            memReadEx  <= memReadId  & validId;
            memWriteEx <= memWriteId & validId;
            memToRegEx <= memToRegId & validId;
            aluSrcEx   <= aluSrcId   & validId;
            aluOpEx    <= validId ? aluOpId : 3'd0;
        end
    end

endmodule

// File: tb/tb_buffer_id_ex.sv
// tb/tb_buffer_id_ex.sv - directed self-checking bench for buffer_id_ex
module tb_buffer_id_ex;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       instrId;
    logic              validId;
    logic [DATA_W-1:0] data1, data2;
    logic              regWriteId, memReadId, memWriteId, memToRegId, aluSrcId, regDstId;
    logic [2:0]        aluOpId;
    logic              flush;
    logic              stall, validEx;
    logic [DATA_W-1:0] data1Ex, data2Ex, immEx;
    logic [4:0]        rsEx, rtEx, wAddrEx;
    logic              regWriteEx, memReadEx, memWriteEx, memToRegEx, aluSrcEx;
    logic [2:0]        aluOpEx;
    logic [CNT_W-1:0]  bubbleCount;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    buffer_id_ex #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instrId(instrId), .validId(validId),
        .data1(data1), .data2(data2),
        .regWriteId(regWriteId), .memReadId(memReadId), .memWriteId(memWriteId),
        .memToRegId(memToRegId), .aluSrcId(aluSrcId), .regDstId(regDstId),
        .aluOpId(aluOpId), .flush(flush), .stall(stall), .validEx(validEx),
        .data1Ex(data1Ex), .data2Ex(data2Ex), .immEx(immEx),
        .rsEx(rsEx), .rtEx(rtEx), .wAddrEx(wAddrEx),
        .regWriteEx(regWriteEx), .memReadEx(memReadEx), .memWriteEx(memWriteEx),
        .memToRegEx(memToRegEx), .aluSrcEx(aluSrcEx), .aluOpEx(aluOpEx),
        .bubbleCount(bubbleCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lw: memRead, regWrite, memToReg, aluSrc, rt destination
    task automatic drive_lw(input logic [31:0] instr, input logic [31:0] d1, input logic [31:0] d2);
        instrId = instr; validId = 1'b1; data1 = d1; data2 = d2;
        regWriteId = 1'b1; memReadId = 1'b1; memWriteId = 1'b0; memToRegId = 1'b1;
        aluSrcId = 1'b1; regDstId = 1'b0; aluOpId = 3'd0;
    endtask

    // R-type add: regWrite, rd destination
    task automatic drive_add(input logic [31:0] instr, input logic [31:0] d1, input logic [31:0] d2);
        instrId = instr; validId = 1'b1; data1 = d1; data2 = d2;
        regWriteId = 1'b1; memReadId = 1'b0; memWriteId = 1'b0; memToRegId = 1'b0;
        aluSrcId = 1'b0; regDstId = 1'b1; aluOpId = 3'd2;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        // reset with random inputs across several edges
        for (int i = 0; i < 3; i++) begin
            instrId = $urandom; validId = 1'b1; data1 = $urandom; data2 = $urandom;
            {regWriteId, memReadId, memWriteId, memToRegId, aluSrcId, regDstId} = 6'h3f;
            aluOpId = 3'(($urandom));
            tick();
        end
        check("rst_valid", {31'd0, validEx}, 32'd0);
        check("rst_data1", data1Ex, 32'd0);
        check("rst_imm", immEx, 32'd0);
        check("rst_ctrl", {27'd0, regWriteEx, memReadEx, memWriteEx, memToRegEx, aluSrcEx}, 32'd0);
        check("rst_waddr", {27'd0, wAddrEx}, 32'd0);
        check("rst_cnt", {30'd0, bubbleCount}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        validId = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", {31'd0, validEx}, 32'd0);
        check("post_rst_ctrl", {29'd0, aluOpEx}, 32'd0);

        // normal capture of lw $3,16($2)
        drive_lw(32'h8C430010, 32'h100, 32'h55);
        #1 check("cap_stall", {31'd0, stall}, 32'd0);
        tick();
        check("cap_valid", {31'd0, validEx}, 32'd1);
        check("cap_rs", {27'd0, rsEx}, 32'd2);
        check("cap_rt", {27'd0, rtEx}, 32'd3);
        check("cap_waddr", {27'd0, wAddrEx}, 32'd3);
        check("cap_imm", immEx, 32'h10);
        check("cap_data1", data1Ex, 32'h100);
        check("cap_data2", data2Ex, 32'h55);
        check("cap_memread", {31'd0, memReadEx}, 32'd1);
        check("cap_ctrl", {27'd0, regWriteEx, memReadEx, memWriteEx, memToRegEx, aluSrcEx}, 32'b11011);

        // load-use: add $5,$3,$4
        drive_add(32'h00642820, 32'h77, 32'h88);
        #1 check("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        check("lu_bub_valid", {31'd0, validEx}, 32'd0);
        check("lu_bub_ctrl", {24'd0, regWriteEx, memReadEx, memWriteEx, memToRegEx, aluSrcEx, aluOpEx}, 32'd0);
        check("lu_bub_cnt", {30'd0, bubbleCount}, 32'd1);
        check("lu_bub_hold_d1", data1Ex, 32'h100);
        check("lu_bub_hold_rt", {27'd0, rtEx}, 32'd3);
        check("lu_bub_stall", {31'd0, stall}, 32'd0);
        tick();
        check("lu_add_valid", {31'd0, validEx}, 32'd1);
        check("lu_add_rs", {27'd0, rsEx}, 32'd3);
        check("lu_add_rt", {27'd0, rtEx}, 32'd4);
        check("lu_add_waddr", {27'd0, wAddrEx}, 32'd5);
        check("lu_add_d1", data1Ex, 32'h77);
        check("lu_add_imm", immEx, 32'h2820);
        check("lu_add_aluop", {29'd0, aluOpEx}, 32'd2);
        check("lu_add_cnt", {30'd0, bubbleCount}, 32'd1);

        // $0 never hazards: lw $0,0($1) then add $5,$0,$4
        drive_lw(32'h8C200000, 32'h1, 32'h2);
        tick();
        check("z_lw_memread", {31'd0, memReadEx}, 32'd1);
        check("z_lw_rt", {27'd0, rtEx}, 32'd0);
        drive_add(32'h00042820, 32'h9, 32'hA);
        #1 check("z_stall", {31'd0, stall}, 32'd0);
        tick();
        check("z_add_valid", {31'd0, validEx}, 32'd1);
        check("z_add_waddr", {27'd0, wAddrEx}, 32'd5);
        check("z_cnt", {30'd0, bubbleCount}, 32'd1);

        // flush beats hazard
        drive_lw(32'h8C430010, 32'h100, 32'h55);
        tick();
        drive_add(32'h00642820, 32'h77, 32'h88);
        #1 check("fl_pre_stall", {31'd0, stall}, 32'd1);
        flush = 1'b1;
        #1 check("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        check("fl_valid", {31'd0, validEx}, 32'd0);
        check("fl_ctrl", {27'd0, regWriteEx, memReadEx, memWriteEx, memToRegEx, aluSrcEx}, 32'd0);
        check("fl_cnt", {30'd0, bubbleCount}, 32'd1);
        check("fl_data1", data1Ex, 32'd0);

        // validId=0 gates control bits
        drive_add(32'h00642820, 32'h1, 32'h2);
        validId = 1'b0;
        tick();
        check("inv_valid", {31'd0, validEx}, 32'd0);
        check("inv_ctrl", {24'd0, regWriteEx, memReadEx, memWriteEx, memToRegEx, aluSrcEx, aluOpEx}, 32'd0);

        // reset asserted mid-stall, cleared asynchronously
        drive_lw(32'h8C430010, 32'h100, 32'h55);
        tick();
        drive_add(32'h00642820, 32'h77, 32'h88);
        #1 check("rs_pre_stall", {31'd0, stall}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check("rs_async_valid", {31'd0, validEx}, 32'd0);
        check("rs_async_data1", data1Ex, 32'd0);
        check("rs_async_cnt", {30'd0, bubbleCount}, 32'd0);
        check("rs_async_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rs_recap_valid", {31'd0, validEx}, 32'd1);
        check("rs_recap_waddr", {27'd0, wAddrEx}, 32'd5);

        // saturation: lw $3,-16($3) depends on itself, bubble every other cycle
        drive_lw(32'h8C63FFF0, 32'h200, 32'h0);
        tick();
        check("sat_imm", immEx, 32'hFFFFFFF0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("sat_stall_%0d", i), {31'd0, stall}, 32'd1);
            tick();
            check($sformatf("sat_cnt_%0d", i), {30'd0, bubbleCount}, (i < 3) ? i + 1 : 3);
            tick();
            check($sformatf("sat_valid_%0d", i), {31'd0, validEx}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
